fifo_rdport_fwft: RTL and testbench

Read-side port controller for the asynchronous FIFO, sitting in the read clock domain opposite the dual-port memory's write port. It owns the binary/Gray read pointer, drives the memory read address, generates the registered empty flag from the synchronized write pointer, and presents data through a 2-entry first-word-fall-through output stage with a valid/ready handshake. It pairs with the existing write-side logic and the pointer synchronizers.

---
 rtl/fifo_rdport_fwft_if.sv | 24 ++
 rtl/fifo_rdport_fwft.sv | 72 +++++++
 tb/tb_fifo_rdport_fwft.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rdport_fwft_if.sv
// rtl/fifo_rdport_fwft_if.sv - read-side FIFO port bundle: memory read port, pointer exchange, FWFT output stream
interface fifo_rdport_fwft_if #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 8
);
  logic [ADDRSIZE:0]   rq2_wptr;
  logic [DATASIZE-1:0] rdata;
  logic [ADDRSIZE-1:0] raddr;
  logic [ADDRSIZE:0]   rptr;
  logic                rempty;
  logic [DATASIZE-1:0] dout;
  logic                dout_valid;
  logic                dout_ready;

  modport master (
    input  rq2_wptr, rdata, dout_ready,
    output raddr, rptr, rempty, dout, dout_valid
  );

  modport slave (
    output rq2_wptr, rdata, dout_ready,
    input  raddr, rptr, rempty, dout, dout_valid
  );
endinterface

// File: rtl/fifo_rdport_fwft.sv
// rtl/fifo_rdport_fwft.sv - async FIFO read pointer, registered empty flag and 2-entry first-word-fall-through output stage
module fifo_rdport_fwft #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 8
) (
  input  logic                rclk,
  input  logic                rrst,
  fifo_rdport_fwft_if.master  rd
);

  logic [ADDRSIZE:0]   rbin_q,   rbin_d;
  logic [ADDRSIZE:0]   rptr_q,   rptr_d;
  logic                rempty_q, rempty_d;
  logic [DATASIZE-1:0] head_q,   head_d;
  logic [DATASIZE-1:0] tail_q,   tail_d;
  logic [1:0]          count_q,  count_d;
  logic                pop;
  logic                fetch;

  always_comb begin
    pop      = (count_q != 2'd0) && rd.dout_ready;
    fetch    = !rempty_q && ((count_q < 2'd2) || pop);
    rbin_d   = rbin_q + (ADDRSIZE+1)'(fetch);
    rptr_d   = (rbin_d >> 1) ^ rbin_d;
    // Empty is judged on the post-increment pointer so the last word is never over-fetched.
    rempty_d = (rptr_d == rd.rq2_wptr);
    count_d  = count_q + 2'(fetch) - 2'(pop);
    head_d   = head_q;
    tail_d   = tail_q;
    case (count_q)
      2'd0: begin
        if (fetch) head_d = rd.rdata;
      end
      2'd1: begin
        if (fetch && !pop) tail_d = rd.rdata;
        if (fetch && pop)  head_d = rd.rdata;
      end
      2'd2: begin
        if (pop) begin
          head_d = tail_q;
          if (fetch) tail_d = rd.rdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin_q   <= '0;
      rptr_q   <= '0;
      rempty_q <= 1'b1;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= 2'd0;
    end else begin
      rbin_q   <= rbin_d;
      rptr_q   <= rptr_d;
      rempty_q <= rempty_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
    end
  end

  assign rd.raddr      = rbin_q[ADDRSIZE-1:0];
  assign rd.rptr       = rptr_q;
  assign rd.rempty     = rempty_q;
  assign rd.dout       = head_q;
  assign rd.dout_valid = (count_q != 2'd0);

endmodule

// File: tb/tb_fifo_rdport_fwft.sv
// tb/tb_fifo_rdport_fwft.sv - self-checking bench for fifo_rdport_fwft against an in-order word scoreboard
module tb_fifo_rdport_fwft;
  localparam int DW = 8;
  localparam int AW = 4;

  logic rclk = 1'b0;
  logic rrst;
  always #5 rclk = ~rclk;

  fifo_rdport_fwft_if #(.DATASIZE(DW), .ADDRSIZE(AW)) bus ();

  logic [DW-1:0] mem [0:(1<<AW)-1];
  assign bus.rdata = mem[bus.raddr];

  fifo_rdport_fwft #(.DATASIZE(DW), .ADDRSIZE(AW)) dut (
    .rclk (rclk),
    .rrst (rrst),
    .rd   (bus.master)
  );

  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] sb [$];
  int unsigned   wbin = 0;
  int            delivered = 0;
  logic          rbin_wrapped = 1'b0;
  logic          raddr_wrapped = 1'b0;

  function automatic logic [AW:0] gray(int unsigned b);
    logic [AW:0] t;
    t = b[AW:0];
    return t ^ (t >> 1);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(logic [DW-1:0] d);
    mem[wbin % (1 << AW)] = d;
    sb.push_back(d);
    wbin++;
    bus.rq2_wptr = gray(wbin);
  endtask

  // One rclk: score the beat accepted on this edge, then check pointer and hold rules after it.
  task automatic cyc();
    logic [AW:0]   prev_rptr;
    logic [AW-1:0] prev_raddr;
    logic [DW-1:0] prev_dout;
    logic [DW-1:0] e;
    logic          hold;
    prev_rptr  = bus.rptr;
    prev_raddr = bus.raddr;
    prev_dout  = bus.dout;
    hold       = (bus.dout_valid === 1'b1) && (bus.dout_ready === 1'b0) && !rrst;
    if ((bus.dout_valid === 1'b1) && bus.dout_ready && !rrst) begin
      if (sb.size() == 0) chk("unexpected_beat", 32'(bus.dout_valid), 32'd0);
      else begin
        e = sb.pop_front();
        chk("beat_data", 32'(bus.dout), 32'(e));
        delivered++;
      end
    end
    @(posedge rclk);
    #1;
    if (!rrst) begin
      if (bus.rptr !== prev_rptr)
        chk("rptr_onebit", 32'($countones(bus.rptr ^ prev_rptr)), 32'd1);
      if (hold) begin
        chk("hold_valid", 32'(bus.dout_valid), 32'd1);
        chk("hold_dout", 32'(bus.dout), 32'(prev_dout));
      end
      if (prev_rptr == 5'b10000 && bus.rptr == 5'b00000) rbin_wrapped = 1'b1;
      if (prev_raddr == 4'hF && bus.raddr == 4'h0) raddr_wrapped = 1'b1;
    end
  endtask

  task automatic do_reset(int n);
    rrst = 1'b1;
    wbin = 0;
    bus.rq2_wptr = '0;
    sb.delete();
    repeat (n) cyc();
    rrst = 1'b0;
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_rptr"},   32'(bus.rptr),       32'd0);
    chk({tag, "_raddr"},  32'(bus.raddr),      32'd0);
    chk({tag, "_rempty"}, 32'(bus.rempty),     32'd1);
    chk({tag, "_valid"},  32'(bus.dout_valid), 32'd0);
    chk({tag, "_dout"},   32'(bus.dout),       32'd0);
  endtask

  initial begin
    int pushed;
    int guard;
    int burst;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    rrst = 1'b1;
    bus.rq2_wptr = '0;
    bus.dout_ready = 1'b1;

    do_reset(2);
    chk_reset_outputs("reset");

    // Single word: empty-to-data latency and consumption
    bus.dout_ready = 1'b0;
    push(8'hA5);
    cyc();
    chk("single_rempty_e1", 32'(bus.rempty), 32'd0);
    chk("single_valid_e1", 32'(bus.dout_valid), 32'd0);
    cyc();
    chk("single_valid_e2", 32'(bus.dout_valid), 32'd1);
    chk("single_dout_e2", 32'(bus.dout), 32'hA5);
    chk("single_rptr_e2", 32'(bus.rptr), 32'b00001);
    chk("single_rempty_e2", 32'(bus.rempty), 32'd1);
    bus.dout_ready = 1'b1;
    cyc();
    chk("single_valid_e3", 32'(bus.dout_valid), 32'd0);

    // Streaming 16 words at full rate
    do_reset(1);
    bus.dout_ready = 1'b1;
    for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
    cyc();
    cyc();
    for (int i = 0; i < 16; i++) begin
      chk("stream_valid", 32'(bus.dout_valid), 32'd1);
      cyc();
    end
    chk("stream_rempty", 32'(bus.rempty), 32'd1);
    chk("stream_rptr", 32'(bus.rptr), 32'b11000);
    chk("stream_raddr", 32'(bus.raddr), 32'd0);
    chk("stream_valid_end", 32'(bus.dout_valid), 32'd0);
    chk("stream_left", 32'(sb.size()), 32'd0);

    // Backpressure: only two words may be pulled while stalled
    do_reset(1);
    bus.dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'($urandom));
    repeat (6) cyc();
    chk("bp_rptr", 32'(bus.rptr), 32'b00011);
    chk("bp_valid", 32'(bus.dout_valid), 32'd1);
    chk("bp_dout", 32'(bus.dout), 32'(sb[0]));
    bus.dout_ready = 1'b1;
    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      cyc();
      guard++;
    end
    chk("bp_left", 32'(sb.size()), 32'd0);
    chk("bp_rptr_end", 32'(bus.rptr), 32'b00111);

    // Reset while the output stage is full and more words are pending
    bus.dout_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(8'($urandom));
    repeat (4) cyc();
    chk("mid_rempty_pre", 32'(bus.rempty), 32'd0);
    chk("mid_valid_pre", 32'(bus.dout_valid), 32'd1);
    bus.dout_ready = 1'b1;
    do_reset(1);
    chk_reset_outputs("mid_reset");
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("mid_no_beat", 32'(bus.dout_valid), 32'd0);
    end

    // Random bursts across the pointer wrap
    delivered = 0;
    pushed = 0;
    guard = 0;
    while (!(pushed == 40 && sb.size() == 0) && guard < 3000) begin
      if (pushed < 40 && ($urandom % 2) == 0) begin
        burst = int'($urandom_range(1, 4));
        for (int k = 0; k < burst; k++)
          if (pushed < 40 && sb.size() < 16) begin
            push(8'($urandom));
            pushed++;
          end
      end
      bus.dout_ready = (($urandom % 3) != 0);
      cyc();
      guard++;
    end
    bus.dout_ready = 1'b1;
    repeat (3) cyc();
    chk("wrap_delivered", 32'(delivered), 32'd40);
    chk("wrap_left", 32'(sb.size()), 32'd0);
    chk("wrap_rbin_wrapped", 32'(rbin_wrapped), 32'd1);
    chk("wrap_raddr_wrapped", 32'(raddr_wrapped), 32'd1);
    chk("wrap_rptr_end", 32'(bus.rptr), 32'(gray(wbin)));
    chk("wrap_rempty_end", 32'(bus.rempty), 32'd1);
    chk("wrap_valid_end", 32'(bus.dout_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
